// File: rtl/vec_lane_packer.sv
// Scalar-to-vector packer feeding the reduction tree: fills N lane pairs from a
// valid/ready sample stream and emits a padded vector on row end or when full.
module vec_lane_packer #(
  parameter int          N     = 8,
  parameter logic [15:0] PAD_0 = 16'h0000,
  parameter logic [15:0] PAD_1 = 16'h0000,
  localparam int         PW    = $clog2(N),
  localparam int         LW    = $clog2(N) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [15:0]       s_data_0,
  input  logic [15:0]       s_data_1,
  input  logic              s_last,
  output logic              valid_out,
  output logic [N*16-1:0]   out_0_flat,
  output logic [N*16-1:0]   out_1_flat,
  output logic [LW-1:0]     out_len,
  output logic              out_last
);

  logic                 rst_meta;
  logic                 rst_q;
  logic [PW-1:0]        wr_ptr;
  logic [N-1:0][15:0]   fill_0;
  logic [N-1:0][15:0]   fill_1;
  logic [N-1:0][15:0]   next_0;
  logic [N-1:0][15:0]   next_1;
  logic                 accept;
  logic                 full;
  logic                 close;
  logic [LW-1:0]        len_next;

  // Reset asserts immediately but releases through two flops so the
  // first accept is always a clean synchronous event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_meta <= 1'b1;
      rst_q    <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_q    <= rst_meta;
    end
  end

  assign s_ready  = en && !rst_q;
  assign accept   = s_valid && s_ready;
  assign full     = (wr_ptr == PW'(N - 1));
  assign close    = accept && (full || s_last);
  assign len_next = LW'(wr_ptr) + LW'(1);

  // Unfilled lanes already hold pad values, so the closing vector is simply
  // the fill buffer with the current sample dropped into its lane.
  always_comb begin
    next_0         = fill_0;
    next_1         = fill_1;
    next_0[wr_ptr] = s_data_0;
    next_1[wr_ptr] = s_data_1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      fill_0     <= {N{PAD_0}};
      fill_1     <= {N{PAD_1}};
      valid_out  <= 1'b0;
      out_0_flat <= {N{PAD_0}};
      out_1_flat <= {N{PAD_1}};
      out_len    <= '0;
      out_last   <= 1'b0;
    end else if (en) begin
      valid_out <= close;
      if (close) begin
        out_0_flat <= next_0;
        out_1_flat <= next_1;
        out_len    <= len_next;
        out_last   <= s_last;
        fill_0     <= {N{PAD_0}};
        fill_1     <= {N{PAD_1}};
        wr_ptr     <= '0;
      end else if (accept) begin
        fill_0 <= next_0;
        fill_1 <= next_1;
        wr_ptr <= wr_ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vec_lane_packer.sv
// Scoreboard bench for vec_lane_packer: stimulus pushes expected vectors,
// a negedge monitor pops and compares each vector the tree consumes.
module tb_vec_lane_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         s_valid;
  logic         s_ready;
  logic [15:0]  s_data_0;
  logic [15:0]  s_data_1;
  logic         s_last;
  logic         valid_out;
  logic [127:0] out_0_flat;
  logic [127:0] out_1_flat;
  logic [3:0]   out_len;
  logic         out_last;

  vec_lane_packer #(.N(8), .PAD_0(16'h0000), .PAD_1(16'h0000)) dut (
    .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready),
    .s_data_0(s_data_0), .s_data_1(s_data_1), .s_last(s_last),
    .valid_out(valid_out), .out_0_flat(out_0_flat), .out_1_flat(out_1_flat),
    .out_len(out_len), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] o0;
    logic [127:0] o1;
    logic [3:0]   len;
    logic         last;
    int           sum;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  int               waits = 0;
  int               vec_count = 0;
  logic [7:0][15:0] m0;
  logic [7:0][15:0] m1;
  int               mptr;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m0 = '0;
    m1 = '0;
    mptr = 0;
  endtask

  // Drive one sample, wait (bounded) for acceptance, update the model.
  task automatic send(input logic [15:0] d0, input logic [15:0] d1, input logic last);
    int   n;
    logic acc;
    exp_t e;
    s_valid = 1'b1; s_data_0 = d0; s_data_1 = d1; s_last = last;
    n = 0;
    forever begin
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1;
      if (acc) break;
      waits++;
      n++;
      if (n > 50) begin
        chk("send_timeout", 128'd1, 128'd0);
        break;
      end
    end
    s_valid = 1'b0;
    if (acc) begin
      m0[mptr] = d0;
      m1[mptr] = d1;
      if (mptr == 7 || last) begin
        e.o0 = m0; e.o1 = m1; e.len = 4'(mptr + 1); e.last = last; e.sum = 0;
        for (int i = 0; i < 8; i++) e.sum += int'(m1[i]);
        sb.push_back(e);
        model_reset();
      end else begin
        mptr++;
      end
    end
  endtask

  // Monitor: the tree consumes a vector on each enabled cycle with valid_out.
  always @(negedge clk) begin
    exp_t e;
    int   s;
    if (!rst && en && valid_out) begin
      vec_count++;
      if (sb.size() == 0) begin
        chk("unexpected_vector", 128'd1, 128'd0);
      end else begin
        e = sb.pop_front();
        s = 0;
        for (int i = 0; i < 8; i++) s += int'(out_1_flat[i*16 +: 16]);
        chk("out_0_flat", out_0_flat, e.o0);
        chk("out_1_flat", out_1_flat, e.o1);
        chk("out_len", 128'(out_len), 128'(e.len));
        chk("out_last", 128'(out_last), 128'(e.last));
        chk("lane_sum", 128'(s), 128'(e.sum));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst = 1'b1; en = 1'b1; s_valid = 1'b0; s_data_0 = '0; s_data_1 = '0; s_last = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_out", 128'(valid_out), 128'd0);
    chk("rst_out_len", 128'(out_len), 128'd0);
    chk("rst_out_0", out_0_flat, 128'd0);
    chk("rst_out_1", out_1_flat, 128'd0);
    chk("rst_s_ready", 128'(s_ready), 128'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Mid-row reset: 3 samples then reset; partial row must vanish.
    for (int i = 0; i < 3; i++) send(16'(300 + i), 16'(60 + i), 1'b0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midrst_valid_out", 128'(valid_out), 128'd0);
    chk("midrst_out_len", 128'(out_len), 128'd0);
    chk("midrst_out_1", out_1_flat, 128'd0);
    chk("midrst_s_ready", 128'(s_ready), 128'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("release_edge1_s_ready", 128'(s_ready), 128'd0);
    @(posedge clk); @(negedge clk);
    chk("release_edge2_s_ready", 128'(s_ready), 128'd1);
    @(posedge clk); #1;

    // Full row: 101..108 / 1..8, sum 36, one cycle latency.
    for (int i = 1; i <= 8; i++) send(16'(100 + i), 16'(i), i == 8);
    @(negedge clk);
    chk("full_latency_valid", 128'(valid_out), 128'd1);
    chk("full_len_direct", 128'(out_len), 128'd8);
    chk("full_sum_direct", 128'(out_1_flat[127:112] + out_1_flat[15:0]), 128'd9);
    @(posedge clk); #1;

    // Short row 5,6,7 then an immediate 4-sample row with no ready gap.
    waits = 0;
    send(16'd201, 16'd5, 1'b0);
    send(16'd202, 16'd6, 1'b0);
    send(16'd203, 16'd7, 1'b1);
    for (int i = 0; i < 4; i++) send(16'(210 + i), 16'(9 + i), i == 3);
    chk("short_no_gap", 128'(waits), 128'd0);

    // Long row of 11: full vector without last, then 3-lane tail.
    for (int i = 0; i < 11; i++) send(16'(400 + i), 16'(21 + i), i == 10);

    // Stall while a vector is presented.
    for (int i = 0; i < 8; i++) send(16'(500 + i), 16'(41 + i), i == 7);
    en = 1'b0; s_valid = 1'b1; s_data_0 = 16'hDEAD; s_data_1 = 16'hBEEF; s_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_valid_held", 128'(valid_out), 128'd1);
      chk("stall_s_ready", 128'(s_ready), 128'd0);
      chk("stall_len_held", 128'(out_len), 128'd8);
      @(posedge clk); #1;
    end
    en = 1'b1; s_valid = 1'b0;

    // Stall mid-fill: 2 lanes in, frozen, then finish a 5-lane row.
    send(16'd600, 16'd51, 1'b0);
    send(16'd601, 16'd52, 1'b0);
    en = 1'b0; s_valid = 1'b1; s_data_0 = 16'hDEAD; s_data_1 = 16'hBEEF; s_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midfill_stall_s_ready", 128'(s_ready), 128'd0);
      @(posedge clk); #1;
    end
    en = 1'b1; s_valid = 1'b0;
    for (int i = 0; i < 3; i++) send(16'(602 + i), 16'(53 + i), i == 2);

    // Back-to-back single-sample rows.
    @(posedge clk); #1;
    base = vec_count;
    waits = 0;
    for (int i = 0; i < 64; i++) send(16'(1000 + i), 16'(i + 1), 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("b2b_no_gap", 128'(waits), 128'd0);
    chk("b2b_pulse_count", 128'(vec_count - base), 128'd64);
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
